// File: rtl/register_file_param_pkg.sv
// Shared sizing helpers and default dimensions for the parametrised register file.
package register_file_param_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_REG_COUNT  = 4;
  localparam int unsigned BYTE_WIDTH         = 8;
  localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / BYTE_WIDTH;

  // Ceiling log2; callers guarantee value >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining != 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/register_file_param_if.sv
// Issue/writeback bus of the register file: write port, reservation port and packed read ports.
interface register_file_param_if import register_file_param_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned REG_COUNT  = DEFAULT_REG_COUNT,
  parameter int unsigned READ_PORTS = 2
);

  localparam int unsigned ADDR_WIDTH = clog2(REG_COUNT);
  localparam int unsigned BYTE_LANES = bytes_per_word(DATA_WIDTH);

  logic                             write_enable;
  logic [ADDR_WIDTH-1:0]            write_register;
  logic [DATA_WIDTH-1:0]            write_data;
  logic [BYTE_LANES-1:0]            write_byte_enable;
  logic                             reserve_enable;
  logic [ADDR_WIDTH-1:0]            reserve_register;
  logic [READ_PORTS*ADDR_WIDTH-1:0] read_register;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0]            read_busy;
  logic [REG_COUNT-1:0]             pending_vector;

  modport master (
    output write_enable,
    output write_register,
    output write_data,
    output write_byte_enable,
    output reserve_enable,
    output reserve_register,
    output read_register,
    input  read_data,
    input  read_busy,
    input  pending_vector
  );

  modport slave (
    input  write_enable,
    input  write_register,
    input  write_data,
    input  write_byte_enable,
    input  reserve_enable,
    input  reserve_register,
    input  read_register,
    output read_data,
    output read_busy,
    output pending_vector
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: storage lookup, optional write bypass, zero register and busy flag.
module regfile_read_port import register_file_param_pkg::*; #(
  parameter int unsigned  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned  REG_COUNT  = DEFAULT_REG_COUNT,
  parameter bit           ZERO_REG   = 1'b0,
  parameter bit           BYPASS     = 1'b1,
  localparam int unsigned ADDR_WIDTH = clog2(REG_COUNT),
  localparam int unsigned BYTE_LANES = bytes_per_word(DATA_WIDTH)
) (
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] regs_flat,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [BYTE_LANES-1:0]           wr_be,
  input  logic                            res_en,
  input  logic [ADDR_WIDTH-1:0]           res_addr,
  input  logic [REG_COUNT-1:0]            pending,
  output logic [DATA_WIDTH-1:0]           data_c,
  output logic                            busy_c
);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] words;
  logic [DATA_WIDTH-1:0]                stored;
  logic [DATA_WIDTH-1:0]                merged;
  logic                                 write_hit;
  logic                                 reserve_hit;

  assign words       = regs_flat;
  assign stored      = words[addr];
  assign write_hit   = BYPASS && wr_en && (wr_addr == addr);
  assign reserve_hit = res_en && (res_addr == addr);

  // Per-lane forwarding: only enabled bytes of a matching write bypass the array.
  for (genvar b = 0; b < BYTE_LANES; b++) begin : g_lane
    assign merged[b*BYTE_WIDTH +: BYTE_WIDTH] = (write_hit && wr_be[b])
                                              ? wr_data[b*BYTE_WIDTH +: BYTE_WIDTH]
                                              : stored[b*BYTE_WIDTH +: BYTE_WIDTH];
  end

  always_comb begin
    data_c = merged;
    if (ZERO_REG && (addr == '0)) begin
      data_c = '0;
    end
  end

  // A retiring producer releases the stall early unless a new producer is issued alongside it.
  always_comb begin
    busy_c = pending[addr];
    if (write_hit && !reserve_hit) begin
      busy_c = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file with byte-enable writes, write bypass and a per-register pending scoreboard.
module register_file_param import register_file_param_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned REG_COUNT  = DEFAULT_REG_COUNT,
  parameter int unsigned READ_PORTS = 2,
  parameter bit          ZERO_REG   = 1'b0,
  parameter bit          BYPASS     = 1'b1
) (
  input logic                  clock,
  input logic                  reset_n,
  register_file_param_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = clog2(REG_COUNT);
  localparam int unsigned BYTE_LANES = bytes_per_word(DATA_WIDTH);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  regs_q;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  regs_d;
  logic [REG_COUNT-1:0]                  pending_q;
  logic [REG_COUNT-1:0]                  pending_d;
  logic [DATA_WIDTH-1:0]                 write_word;
  logic                                  write_commit;
  logic                                  reserve_commit;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]                 rd_busy;

  // Register 0 silently drops writes and reservations when hardwired to zero.
  assign write_commit   = bus.write_enable
                          && !(ZERO_REG && (bus.write_register == '0));
  assign reserve_commit = bus.reserve_enable
                          && !(ZERO_REG && (bus.reserve_register == '0));

  for (genvar b = 0; b < BYTE_LANES; b++) begin : g_wlane
    assign write_word[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.write_byte_enable[b]
                                                  ? bus.write_data[b*BYTE_WIDTH +: BYTE_WIDTH]
                                                  : regs_q[bus.write_register][b*BYTE_WIDTH +: BYTE_WIDTH];
  end

  always_comb begin
    regs_d = regs_q;
    if (write_commit) begin
      regs_d[bus.write_register] = write_word;
    end
  end

  // Reservation is applied after the writeback clear so a same-register reserve wins.
  always_comb begin
    pending_d = pending_q;
    if (bus.write_enable) begin
      pending_d[bus.write_register] = 1'b0;
    end
    if (reserve_commit) begin
      pending_d[bus.reserve_register] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_COUNT  (REG_COUNT),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_read_port (
      .addr      (bus.read_register[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .regs_flat (regs_q),
      .wr_en     (write_commit),
      .wr_addr   (bus.write_register),
      .wr_data   (bus.write_data),
      .wr_be     (bus.write_byte_enable),
      .res_en    (reserve_commit),
      .res_addr  (bus.reserve_register),
      .pending   (pending_q),
      .data_c    (rd_data[p]),
      .busy_c    (rd_busy[p])
    );
  end

  assign bus.read_data      = rd_data;
  assign bus.read_busy      = rd_busy;
  assign bus.pending_vector = pending_q;

endmodule

// File: tb/tb_register_file_param.sv
// Bench: two configurations (bypass/no zero reg, and no bypass/zero reg) driven by one vector table.
module tb_register_file_param;

  localparam int unsigned DW = 32;
  localparam int unsigned RC = 4;
  localparam int unsigned RP = 2;
  localparam int          NVEC = 20;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [3:0]  pend;
  } obs_t;

  typedef struct {
    logic        we;
    logic [1:0]  wr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [1:0]  rr;
    logic [1:0]  ra0;
    logic [1:0]  ra1;
    obs_t        a;
    obs_t        b;
  } vec_t;

  typedef struct {
    int   tag;
    obs_t a;
    obs_t b;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[NVEC];

  always #5 clock = ~clock;

  register_file_param_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP)) bus_a ();
  register_file_param_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP)) bus_b ();

  register_file_param #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP), .ZERO_REG(1'b0), .BYPASS(1'b1)
  ) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  register_file_param #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  function automatic obs_t mk_obs(input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [1:0] busy, input logic [3:0] pend);
    obs_t o;
    o.d0 = d0; o.d1 = d1; o.busy = busy; o.pend = pend;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic we, input logic [1:0] wr, input logic [31:0] wd,
                                  input logic [3:0] be, input logic re, input logic [1:0] rr,
                                  input logic [1:0] ra0, input logic [1:0] ra1,
                                  input obs_t a, input obs_t b);
    vec_t v;
    v.we = we; v.wr = wr; v.wd = wd; v.be = be; v.re = re; v.rr = rr;
    v.ra0 = ra0; v.ra1 = ra1; v.a = a; v.b = b;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [1:0] wr, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [1:0] rr,
                       input logic [1:0] ra0, input logic [1:0] ra1);
    bus_a.write_enable = we;  bus_b.write_enable = we;
    bus_a.write_register = wr; bus_b.write_register = wr;
    bus_a.write_data = wd;    bus_b.write_data = wd;
    bus_a.write_byte_enable = be; bus_b.write_byte_enable = be;
    bus_a.reserve_enable = re; bus_b.reserve_enable = re;
    bus_a.reserve_register = rr; bus_b.reserve_register = rr;
    bus_a.read_register = {ra1, ra0};
    bus_b.read_register = {ra1, ra0};
  endtask

  task automatic apply(input int tag, input vec_t v);
    exp_t e;
    drive(v.we, v.wr, v.wd, v.be, v.re, v.rr, v.ra0, v.ra1);
    e.tag = tag; e.a = v.a; e.b = v.b;
    exp_q.push_back(e);
  endtask

  task automatic check(input int tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, tag, act, exp);
    end
  endtask

  task automatic check_obs(input int tag, input string who, input logic [63:0] data,
                           input logic [1:0] busy, input logic [3:0] pend, input obs_t e);
    check(tag, {who, ".read_data0"}, data[31:0], e.d0);
    check(tag, {who, ".read_data1"}, data[63:32], e.d1);
    check(tag, {who, ".read_busy"}, 32'(busy), 32'(e.busy));
    check(tag, {who, ".pending_vector"}, 32'(pend), 32'(e.pend));
  endtask

  // Comparator: combinational outputs are sampled mid-cycle, before the edge commits.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check_obs(cur.tag, "a", bus_a.read_data, bus_a.read_busy, bus_a.pending_vector, cur.a);
      check_obs(cur.tag, "b", bus_b.read_data, bus_b.read_busy, bus_b.pending_vector, cur.b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0, 2'd1);

    //                we    wr    wd            be    re    rr    ra0   ra1   dut_a: d0 d1 busy pend                         dut_b
    vecs[0]  = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd0, 2'd1, mk_obs(32'h0, 32'h0, 2'b00, 4'b0000), mk_obs(32'h0, 32'h0, 2'b00, 4'b0000));
    vecs[1]  = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd2, 2'd3, mk_obs(32'h0, 32'h0, 2'b00, 4'b0000), mk_obs(32'h0, 32'h0, 2'b00, 4'b0000));
    vecs[2]  = mk_vec(1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 1'b0, 2'd0, 2'd2, 2'd2, mk_obs(32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 4'b0000), mk_obs(32'h0, 32'h0, 2'b00, 4'b0000));
    vecs[3]  = mk_vec(1'b1, 2'd2, 32'h000000AA, 4'h1, 1'b0, 2'd0, 2'd2, 2'd2, mk_obs(32'hDEADBEAA, 32'hDEADBEAA, 2'b00, 4'b0000), mk_obs(32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 4'b0000));
    vecs[4]  = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd2, 2'd2, mk_obs(32'hDEADBEAA, 32'hDEADBEAA, 2'b00, 4'b0000), mk_obs(32'hDEADBEAA, 32'hDEADBEAA, 2'b00, 4'b0000));
    vecs[5]  = mk_vec(1'b1, 2'd3, 32'h12345678, 4'hF, 1'b0, 2'd0, 2'd3, 2'd2, mk_obs(32'h12345678, 32'hDEADBEAA, 2'b00, 4'b0000), mk_obs(32'h0, 32'hDEADBEAA, 2'b00, 4'b0000));
    vecs[6]  = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd3, 2'd3, mk_obs(32'h12345678, 32'h12345678, 2'b00, 4'b0000), mk_obs(32'h12345678, 32'h12345678, 2'b00, 4'b0000));
    vecs[7]  = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 2'd1, 2'd1, 2'd1, mk_obs(32'h0, 32'h0, 2'b00, 4'b0000), mk_obs(32'h0, 32'h0, 2'b00, 4'b0000));
    vecs[8]  = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd0, 2'd1, mk_obs(32'h0, 32'h0, 2'b10, 4'b0010), mk_obs(32'h0, 32'h0, 2'b10, 4'b0010));
    vecs[9]  = mk_vec(1'b1, 2'd1, 32'hCAFEF00D, 4'hF, 1'b0, 2'd0, 2'd1, 2'd1, mk_obs(32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4'b0010), mk_obs(32'h0, 32'h0, 2'b11, 4'b0010));
    vecs[10] = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd1, 2'd1, mk_obs(32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4'b0000), mk_obs(32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4'b0000));
    vecs[11] = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 2'd1, 2'd1, 2'd1, mk_obs(32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4'b0000), mk_obs(32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4'b0000));
    vecs[12] = mk_vec(1'b1, 2'd1, 32'h11111111, 4'hF, 1'b1, 2'd1, 2'd1, 2'd0, mk_obs(32'h11111111, 32'h0, 2'b01, 4'b0010), mk_obs(32'hCAFEF00D, 32'h0, 2'b01, 4'b0010));
    vecs[13] = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd1, 2'd1, mk_obs(32'h11111111, 32'h11111111, 2'b11, 4'b0010), mk_obs(32'h11111111, 32'h11111111, 2'b11, 4'b0010));
    vecs[14] = mk_vec(1'b1, 2'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 2'd0, 2'd0, 2'd0, mk_obs(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 4'b0010), mk_obs(32'h0, 32'h0, 2'b00, 4'b0010));
    vecs[15] = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd0, 2'd1, mk_obs(32'hFFFFFFFF, 32'h11111111, 2'b11, 4'b0011), mk_obs(32'h0, 32'h11111111, 2'b10, 4'b0010));
    vecs[16] = mk_vec(1'b1, 2'd1, 32'hAAAAAAAA, 4'h0, 1'b0, 2'd0, 2'd1, 2'd0, mk_obs(32'h11111111, 32'hFFFFFFFF, 2'b10, 4'b0011), mk_obs(32'h11111111, 32'h0, 2'b01, 4'b0010));
    vecs[17] = mk_vec(1'b1, 2'd0, 32'h00000000, 4'hF, 1'b0, 2'd0, 2'd0, 2'd1, mk_obs(32'h0, 32'h11111111, 2'b00, 4'b0001), mk_obs(32'h0, 32'h11111111, 2'b00, 4'b0000));
    vecs[18] = mk_vec(1'b1, 2'd3, 32'h00000055, 4'hF, 1'b1, 2'd2, 2'd2, 2'd3, mk_obs(32'hDEADBEAA, 32'h00000055, 2'b00, 4'b0000), mk_obs(32'hDEADBEAA, 32'h12345678, 2'b00, 4'b0000));
    vecs[19] = mk_vec(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 2'd0, 2'd2, 2'd3, mk_obs(32'hDEADBEAA, 32'h00000055, 2'b01, 4'b0100), mk_obs(32'hDEADBEAA, 32'h00000055, 2'b01, 4'b0100));

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clock);
      #1;
      apply(i, vecs[i]);
    end

    // Asynchronous reset pulse in the middle of a cycle, no clock edge involved.
    @(posedge clock);
    #1;
    drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd2, 2'd3);
    #1;
    check(100, "a.pending_before_reset", 32'(bus_a.pending_vector), 32'h4);
    check(100, "b.pending_before_reset", 32'(bus_b.pending_vector), 32'h4);
    reset_n = 1'b0;
    #1;
    check(101, "a.pending_in_reset", 32'(bus_a.pending_vector), 32'h0);
    check(101, "b.pending_in_reset", 32'(bus_b.pending_vector), 32'h0);
    for (int r = 0; r < 4; r++) begin
      bus_a.read_register = {2'(r), 2'(r)};
      bus_b.read_register = {2'(r), 2'(r)};
      #1;
      check(110 + r, "a.data_in_reset", bus_a.read_data[31:0], 32'h0);
      check(110 + r, "a.data1_in_reset", bus_a.read_data[63:32], 32'h0);
      check(110 + r, "b.data_in_reset", bus_b.read_data[31:0], 32'h0);
      check(110 + r, "a.busy_in_reset", 32'(bus_a.read_busy), 32'h0);
    end
    reset_n = 1'b1;

    // A write after reset lands normally and leaves the scoreboard clear.
    @(posedge clock);
    #1;
    apply(200, mk_vec(1'b1, 2'd2, 32'hA5A5A5A5, 4'hF, 1'b0, 2'd0, 2'd2, 2'd3,
                      mk_obs(32'hA5A5A5A5, 32'h0, 2'b00, 4'b0000),
                      mk_obs(32'h0, 32'h0, 2'b00, 4'b0000)));
    @(posedge clock);
    #1;
    apply(201, mk_vec(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd2, 2'd0,
                      mk_obs(32'hA5A5A5A5, 32'h0, 2'b00, 4'b0000),
                      mk_obs(32'hA5A5A5A5, 32'h0, 2'b00, 4'b0000)));
    @(posedge clock);
    @(negedge clock);
    #1;
    check(300, "scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised, clocked successor to the 4x32 two-read-port register file.
- Width, depth and read-port count are configurable. Adds byte-enable writes, an optional hardwired zero register and optional write-to-read bypass.
- Adds a per-register pending scoreboard so an issue stage can reserve a destination and stall dependent reads until writeback.
- Sits between decode/issue (reads, reservations) and writeback (writes) of the datapath.

Parameters:
- DATA_WIDTH, 32, bits per register; must be a multiple of 8.
- REG_COUNT, 4, number of registers; power of two, at least 2.
- READ_PORTS, 2, number of independent read ports, 1 to 4.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and reservations, and is never busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.
- ADDR_WIDTH, clog2(REG_COUNT), derived; not to be overridden.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- write_enable  in  1  commit write this cycle
- write_register  in  ADDR_WIDTH  write destination
- write_data  in  DATA_WIDTH  write value
- write_byte_enable  in  DATA_WIDTH/8  per-byte write mask
- reserve_enable  in  1  mark a register pending this cycle
- reserve_register  in  ADDR_WIDTH  register to mark pending
- read_register  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  READ_PORTS*DATA_WIDTH  packed read data, same packing
- read_busy  out  READ_PORTS  per-port: addressed register is pending
- pending_vector  out  REG_COUNT  raw scoreboard state

Behaviour:
- Reset (reset_n low, asynchronous): all registers go to 0 and all pending bits clear. read_data therefore shows 0, and read_busy and pending_vector are 0.
- Write: on a rising clock edge with write_enable high, byte b of write_register takes write_data byte b where write_byte_enable[b] is 1. Other bytes hold. An all-zero mask updates nothing but still clears pending.
- Read: combinational, zero latency.
  - read_data for port p is the stored value of read_register[p].
  - With BYPASS=1, if write_enable is high and write_register matches, the enabled bytes come from write_data and the others from the stored value.
  - With BYPASS=0, the read returns the stored value; the new value appears the cycle after the edge.
- Zero register (ZERO_REG=1): reads of register 0 return 0, including under bypass. Writes to register 0 are dropped. pending_vector[0] is always 0.
- Scoreboard, per register, at a clock edge:
  - The pending bit sets on reserve_enable to that register.
  - It clears on write_enable to that register.
  - Reserve and write to the same register in the same cycle: reserve wins and the bit stays/sets to 1 (a new producer was issued).
  - Reserve and write to different registers: both take effect.
  - Reserving an already-pending register: the bit stays 1, with no error or count.
- read_busy for port p:
  - It equals pending[read_register[p]].
  - With BYPASS=1 it is also forced 0 when a same-cycle write targets that register and no same-cycle reserve targets it.
  - With BYPASS=0 there is no such override.
- Multiple read ports may address the same register and each gets an identical result.
- Reset asserted mid-operation aborts any in-flight write and clears the scoreboard immediately. Any pending write that arrives after reset is applied normally and leaves the pending bit 0.
- No X may propagate to read_data from any in-range address. All addresses are in range by construction, since REG_COUNT is a power of two.

Decomposition:
- Shared package holds:
  - the clog2 function;
  - DATA_WIDTH/REG_COUNT defaults as localparams;
  - a BYTES_PER_WORD helper constant.
- Sub-module regfile_read_port: one instance per read port, generated. It takes the address, the storage array flat bus, write-bypass inputs and the pending vector, and produces data and busy.
- Storage, byte-enable write logic and scoreboard stay in the top module.

Test Plan:
- Reset then read all ports of all registers -> every read_data 0, read_busy 0, pending_vector 0.
- Write reg 2 = 0xDEADBEEF with mask 4'b1111, then write reg 2 = 0x000000AA with mask 4'b0001 -> reg 2 reads 0xDEADBEAA on both ports.
- BYPASS=1: port 0 reads reg 3 while writing reg 3 = 0x12345678 in the same cycle -> read_data port 0 shows 0x12345678 in that cycle. BYPASS=0 -> old value that cycle, new value the next cycle.
- Reserve reg 1 -> pending_vector=4'b0010 and port 1 on reg 1 has read_busy=1. Write reg 1 -> busy drops in the write cycle under bypass and the bit clears after the edge. Simultaneous reserve+write reg 1 -> pending stays 1.
- ZERO_REG=1: write reg 0 = 0xFFFFFFFF and reserve reg 0 -> reads 0, pending_vector[0]=0, read_busy 0.
- Reserve reg 2 and write reg 3 = 0x55, then pulse reset_n low mid-cycle -> pending_vector 0 and all reads 0 immediately, without waiting for a clock edge.
